// File: rtl/cpu_defines.sv
// Shared pipeline-control types: stall vector encoding, sequencer states and
// a saturating counter helper used by the optional perf counters.
package cpu_defines;

   localparam int unsigned STALL_W    = 6;
   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned PERF_W     = 32;

   // Hold bits {wb, mem, ex, id, if, pc}; bit 0 is the PC.
   typedef logic [STALL_W-1:0] Stall_t;

   localparam Stall_t STALL_NONE     = 6'b000000;
   localparam Stall_t STALL_LOAD_USE = 6'b000111;
   localparam Stall_t STALL_MC       = 6'b001111;
   localparam Stall_t STALL_MEM      = 6'b011111;
   localparam Stall_t STALL_ALL      = 6'b111111;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MC_WAIT = 2'd1,
      FLUSH   = 2'd2
   } Pipe_ctrl_state_t;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v,
                                                 input logic              en);
      return (en && (v != {PERF_W{1'b1}})) ? v + PERF_W'(1) : v;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator: a load in EX feeding a register that ID reads
// this cycle, which forwarding cannot resolve.
module load_use_detect
   import cpu_defines::*;
(
   input  logic                  id_reg1_read_i,
   input  logic                  id_reg2_read_i,
   input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_wreg_write_i,
   input  logic [REG_ADDR_W-1:0] ex_wreg_addr_i,
   output logic                  hazard_o
);

   logic reg1_hit;
   logic reg2_hit;

   always_comb begin
      reg1_hit = id_reg1_read_i && (id_reg1_addr_i == ex_wreg_addr_i);
      reg2_hit = id_reg2_read_i && (id_reg2_addr_i == ex_wreg_addr_i);
      // Writes to $0 are discarded, so they never create a dependency.
      hazard_o = ex_mem_read_i && ex_wreg_write_i &&
                 (ex_wreg_addr_i != REG_ADDR_W'(0)) && (reg1_hit || reg2_hit);
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: global stall vector, exception flush/redirect and
// multi-cycle EX timing. Define PIPE_CTRL_PERF_EN to build stall-cause counters.
module pipe_ctrl
   import cpu_defines::*;
#(
   parameter int unsigned MC_LEN_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  id_reg1_read_i,
   input  logic                  id_reg2_read_i,
   input  logic [REG_ADDR_W-1:0] id_reg1_addr_i,
   input  logic [REG_ADDR_W-1:0] id_reg2_addr_i,
   input  logic                  ex_mem_read_i,
   input  logic                  ex_wreg_write_i,
   input  logic [REG_ADDR_W-1:0] ex_wreg_addr_i,
   input  logic                  ex_mc_start_i,
   input  logic [MC_LEN_W-1:0]   ex_mc_len_i,
   input  logic                  mem_stallreq_i,
   input  logic                  flush_req_i,
   input  logic [XLEN-1:0]       flush_pc_i,
   output Stall_t                stall_o,
   output logic                  flush_o,
   output logic [XLEN-1:0]       new_pc_o,
   output logic                  ex_mc_done_o,
   output logic [PERF_W-1:0]     perf_load_use_o,
   output logic [PERF_W-1:0]     perf_mc_o,
   output logic [PERF_W-1:0]     perf_mem_o,
   output logic [PERF_W-1:0]     perf_flush_o
);

   Pipe_ctrl_state_t      state_q, state_d;
   logic [MC_LEN_W-1:0]   cnt_q, cnt_d;
   logic                  done_q, done_d;
   logic                  flush_q, flush_d;
   logic [XLEN-1:0]       new_pc_q, new_pc_d;

   logic                  load_use;
   logic                  mc_busy;
   logic [MC_LEN_W-1:0]   mc_len_eff;
   Stall_t                stall_c;

   load_use_detect u_load_use_detect (
      .id_reg1_read_i  (id_reg1_read_i),
      .id_reg2_read_i  (id_reg2_read_i),
      .id_reg1_addr_i  (id_reg1_addr_i),
      .id_reg2_addr_i  (id_reg2_addr_i),
      .ex_mem_read_i   (ex_mem_read_i),
      .ex_wreg_write_i (ex_wreg_write_i),
      .ex_wreg_addr_i  (ex_wreg_addr_i),
      .hazard_o        (load_use)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= RUN;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         flush_q  <= 1'b0;
         new_pc_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         flush_q  <= flush_d;
         new_pc_q <= new_pc_d;
      end
   end

   // Next state, multi-cycle countdown and registered pulse requests.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      flush_d    = 1'b0;
      new_pc_d   = '0;
      mc_busy    = 1'b0;
      mc_len_eff = (ex_mc_len_i == MC_LEN_W'(0)) ? MC_LEN_W'(1) : ex_mc_len_i;

      unique case (state_q)
         RUN: begin
            if (flush_req_i) begin
               state_d  = FLUSH;
               flush_d  = 1'b1;
               new_pc_d = flush_pc_i;
            end else if (ex_mc_start_i) begin
               mc_busy = 1'b1;
               if (mc_len_eff == MC_LEN_W'(1)) begin
                  done_d = 1'b1;
               end else begin
                  state_d = MC_WAIT;
                  cnt_d   = mc_len_eff - MC_LEN_W'(1);
               end
            end
         end
         MC_WAIT: begin
            mc_busy = 1'b1;
            if (flush_req_i) begin
               state_d  = FLUSH;
               cnt_d    = '0;
               flush_d  = 1'b1;
               new_pc_d = flush_pc_i;
            end else begin
               // cnt holds the stall cycles still owed, this one included.
               cnt_d = cnt_q - MC_LEN_W'(1);
               if (cnt_q == MC_LEN_W'(1)) begin
                  state_d = RUN;
                  done_d  = 1'b1;
               end
            end
         end
         FLUSH: begin
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Prioritised stall decision; requests are ignored while the flush is out.
   always_comb begin
      stall_c = STALL_NONE;
      if (state_q != FLUSH) begin
         if (flush_req_i)         stall_c = STALL_ALL;
         else if (mem_stallreq_i) stall_c = STALL_MEM;
         else if (mc_busy)        stall_c = STALL_MC;
         else if (load_use)       stall_c = STALL_LOAD_USE;
      end
      stall_o = rst ? stall_c : STALL_NONE;
   end

   assign flush_o      = flush_q;
   assign new_pc_o     = new_pc_q;
   assign ex_mc_done_o = done_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [PERF_W-1:0] perf_lu_q, perf_mc_q, perf_mem_q, perf_flush_q;

   // One increment per cycle for the cause that won the stall priority.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_lu_q    <= '0;
         perf_mc_q    <= '0;
         perf_mem_q   <= '0;
         perf_flush_q <= '0;
      end else begin
         perf_lu_q    <= sat_inc(perf_lu_q,    stall_c == STALL_LOAD_USE);
         perf_mc_q    <= sat_inc(perf_mc_q,    stall_c == STALL_MC);
         perf_mem_q   <= sat_inc(perf_mem_q,   stall_c == STALL_MEM);
         perf_flush_q <= sat_inc(perf_flush_q, stall_c == STALL_ALL);
      end
   end

   assign perf_load_use_o = perf_lu_q;
   assign perf_mc_o       = perf_mc_q;
   assign perf_mem_o      = perf_mem_q;
   assign perf_flush_o    = perf_flush_q;
`else
   assign perf_load_use_o = '0;
   assign perf_mc_o       = '0;
   assign perf_mem_o      = '0;
   assign perf_flush_o    = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios then random traffic,
// compared every cycle against a remaining-stall-cycles reference model.
module tb_pipe_ctrl;

   localparam int unsigned MC_LEN_W = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_reg1_read_i, id_reg2_read_i;
   logic [4:0]  id_reg1_addr_i, id_reg2_addr_i;
   logic        ex_mem_read_i, ex_wreg_write_i;
   logic [4:0]  ex_wreg_addr_i;
   logic        ex_mc_start_i;
   logic [MC_LEN_W-1:0] ex_mc_len_i;
   logic        mem_stallreq_i, flush_req_i;
   logic [31:0] flush_pc_i;
   logic [5:0]  stall_o;
   logic        flush_o, ex_mc_done_o;
   logic [31:0] new_pc_o;
   logic [31:0] perf_load_use_o, perf_mc_o, perf_mem_o, perf_flush_o;

   pipe_ctrl #(.MC_LEN_W(MC_LEN_W)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_reg1_read_i  (id_reg1_read_i),
      .id_reg2_read_i  (id_reg2_read_i),
      .id_reg1_addr_i  (id_reg1_addr_i),
      .id_reg2_addr_i  (id_reg2_addr_i),
      .ex_mem_read_i   (ex_mem_read_i),
      .ex_wreg_write_i (ex_wreg_write_i),
      .ex_wreg_addr_i  (ex_wreg_addr_i),
      .ex_mc_start_i   (ex_mc_start_i),
      .ex_mc_len_i     (ex_mc_len_i),
      .mem_stallreq_i  (mem_stallreq_i),
      .flush_req_i     (flush_req_i),
      .flush_pc_i      (flush_pc_i),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .new_pc_o        (new_pc_o),
      .ex_mc_done_o    (ex_mc_done_o),
      .perf_load_use_o (perf_load_use_o),
      .perf_mc_o       (perf_mc_o),
      .perf_mem_o      (perf_mem_o),
      .perf_flush_o    (perf_flush_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: stall cycles still owed after this one, pending pulses.
   int          mc_rem;
   bit          exp_done, exp_flush;
   logic [31:0] exp_pc;
   int          c_lu, c_mc, c_mem, c_fl;

   task automatic model_reset();
      mc_rem = 0; exp_done = 0; exp_flush = 0; exp_pc = 0;
      c_lu = 0; c_mc = 0; c_mem = 0; c_fl = 0;
   endtask

   function automatic bit hazard();
      return ex_mem_read_i && ex_wreg_write_i && (ex_wreg_addr_i != 0) &&
             ((id_reg1_read_i && id_reg1_addr_i == ex_wreg_addr_i) ||
              (id_reg2_read_i && id_reg2_addr_i == ex_wreg_addr_i));
   endfunction

   function automatic logic [5:0] exp_stall();
      if (!rst || exp_flush)           return 6'd0;
      if (flush_req_i)                 return 6'b111111;
      if (mem_stallreq_i)              return 6'b011111;
      if (mc_rem > 0 || ex_mc_start_i) return 6'b001111;
      if (hazard())                    return 6'b000111;
      return 6'd0;
   endfunction

   task automatic model_edge();
      logic [5:0] s;
      bit nd, nf;
      int eff;
      nd = 0; nf = 0;
      if (!rst) begin
         model_reset();
      end else begin
         s = exp_stall();
         if (s == 6'b111111) c_fl++;
         if (s == 6'b011111) c_mem++;
         if (s == 6'b001111) c_mc++;
         if (s == 6'b000111) c_lu++;
         if (exp_flush) begin
            // redirect cycle: every request is dropped
         end else if (flush_req_i) begin
            nf = 1; exp_pc = flush_pc_i; mc_rem = 0;
         end else if (mc_rem > 0) begin
            mc_rem--;
            if (mc_rem == 0) nd = 1;
         end else if (ex_mc_start_i) begin
            eff = (ex_mc_len_i == 0) ? 1 : int'(ex_mc_len_i);
            mc_rem = eff - 1;
            if (mc_rem == 0) nd = 1;
         end
         exp_done = nd; exp_flush = nf;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic check_all(input string ph);
      chk({ph, ".stall"}, 32'(stall_o), 32'(exp_stall()));
      chk({ph, ".done"},  32'(ex_mc_done_o), 32'(exp_done));
      chk({ph, ".flush"}, 32'(flush_o), 32'(exp_flush));
      chk({ph, ".new_pc"}, new_pc_o, exp_flush ? exp_pc : 32'd0);
`ifdef PIPE_CTRL_PERF_EN
      chk({ph, ".perf_lu"},  perf_load_use_o, 32'(c_lu));
      chk({ph, ".perf_mc"},  perf_mc_o,       32'(c_mc));
      chk({ph, ".perf_mem"}, perf_mem_o,      32'(c_mem));
      chk({ph, ".perf_fl"},  perf_flush_o,    32'(c_fl));
`else
      chk({ph, ".perf_lu"},  perf_load_use_o, 32'd0);
      chk({ph, ".perf_mc"},  perf_mc_o,       32'd0);
      chk({ph, ".perf_mem"}, perf_mem_o,      32'd0);
      chk({ph, ".perf_fl"},  perf_flush_o,    32'd0);
`endif
   endtask

   // Inputs are set before the call; checked at negedge, model steps at posedge.
   task automatic tick(input string ph);
      @(negedge clk);
      check_all(ph);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle();
      id_reg1_read_i = 0; id_reg2_read_i = 0; id_reg1_addr_i = 0; id_reg2_addr_i = 0;
      ex_mem_read_i = 0; ex_wreg_write_i = 0; ex_wreg_addr_i = 0;
      ex_mc_start_i = 0; ex_mc_len_i = 0; mem_stallreq_i = 0;
      flush_req_i = 0; flush_pc_i = 0;
   endtask

   task automatic mc_start(input int len);
      ex_mc_start_i = 1; ex_mc_len_i = MC_LEN_W'(len);
   endtask

   initial begin
      rst = 1'b0;
      idle();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b1;

      // load-use through operand 1, then the load moves on to MEM
      ex_mem_read_i = 1; ex_wreg_write_i = 1; ex_wreg_addr_i = 5'd3;
      id_reg1_read_i = 1; id_reg1_addr_i = 5'd3;
      #1 chk("lu_literal", 32'(stall_o), 32'h07);
      tick("lu1");
      ex_mem_read_i = 0; ex_wreg_write_i = 0;
      tick("lu1_proceed");
      // operand 2 path, and destination $0
      idle();
      ex_mem_read_i = 1; ex_wreg_write_i = 1; ex_wreg_addr_i = 5'd9;
      id_reg2_read_i = 1; id_reg2_addr_i = 5'd9;
      tick("lu2");
      ex_wreg_addr_i = 5'd0; id_reg2_addr_i = 5'd0; id_reg1_read_i = 1;
      #1 chk("lu_zero_literal", 32'(stall_o), 32'h00);
      tick("lu_zero");
      idle();

      // multi-cycle len 4: four stall cycles then one done cycle
      mc_start(4);
      tick("mc4_start");
      idle();
      repeat (3) tick("mc4_wait");
      #1 chk("mc4_done_literal", 32'(ex_mc_done_o), 32'd1);
      tick("mc4_done");
      tick("mc4_after");

      // len 0 behaves as len 1
      mc_start(0);
      tick("mc0_start");
      idle();
      tick("mc0_done");
      tick("mc0_after");

      // len 6 with a three-cycle MEM wait inside
      mc_start(6);
      tick("mc6_start");
      idle();
      tick("mc6_w1");
      mem_stallreq_i = 1;
      repeat (3) tick("mc6_mem");
      mem_stallreq_i = 0;
      tick("mc6_w5");
      tick("mc6_done");
      tick("mc6_after");

      // exception during MC_WAIT aborts the op
      mc_start(5);
      tick("fl_start");
      idle();
      tick("fl_wait");
      flush_req_i = 1; flush_pc_i = 32'hBFC0_0380;
      tick("fl_req");
      idle();
      #1 chk("fl_pc_literal", new_pc_o, 32'hBFC0_0380);
      tick("fl_out");
      repeat (4) tick("fl_quiet");

      // flush and start together: flush wins
      mc_start(3); flush_req_i = 1; flush_pc_i = 32'h8000_0180;
      tick("fl_vs_mc");
      idle();
      tick("fl_vs_mc_out");
      tick("fl_vs_mc_after");

      // reset mid-MC_WAIT
      mc_start(8);
      tick("rst_start");
      idle();
      tick("rst_wait");
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(negedge clk);
      #1 rst = 1'b1;
      repeat (8) tick("rst_after");

      // random traffic
      for (int i = 0; i < 400; i++) begin
         id_reg1_read_i  = 1'($urandom_range(0, 1));
         id_reg2_read_i  = 1'($urandom_range(0, 1));
         id_reg1_addr_i  = 5'($urandom_range(0, 5));
         id_reg2_addr_i  = 5'($urandom_range(0, 5));
         ex_mem_read_i   = 1'($urandom_range(0, 1));
         ex_wreg_write_i = 1'($urandom_range(0, 1));
         ex_wreg_addr_i  = 5'($urandom_range(0, 5));
         ex_mc_start_i   = ($urandom_range(0, 7) == 0);
         ex_mc_len_i     = MC_LEN_W'($urandom_range(0, 9));
         mem_stallreq_i  = ($urandom_range(0, 4) == 0);
         flush_req_i     = ($urandom_range(0, 24) == 0);
         flush_pc_i      = $urandom;
         tick("rand");
      end
      idle();
      repeat (12) tick("drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
